plot_bitmap_scheduler: RTL and testbench

Sequences the 1-bit downsampled bitmap (the 80x106 black/white frame held in block RAM) into the stepper-plotter controller one pixel per plotter request. It owns the bitmap read port during a plot, orders pixels in raster or serpentine order, and freezes bitmap writes for the duration of the plot. It sits between the bitmap BRAM read side and `plotter_control` (`pixel_value_in` / `ready_next_pixel`) in the 65 MHz domain.

---
 rtl/plot_bitmap_scheduler_if.sv | 36 +++
 rtl/plot_bitmap_scheduler.sv | 161 ++++++++++++++++
 tb/tb_plot_bitmap_scheduler.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/plot_bitmap_scheduler_if.sv
// Bitmap-scheduler bus: plot control, bitmap BRAM read side and the pixel stream to the plotter.
interface plot_bitmap_scheduler_if #(
    parameter int unsigned WIDTH  = 80,
    parameter int unsigned HEIGHT = 106,
    parameter int unsigned ADDR_W = 17
);
    localparam int unsigned ColW = $clog2(WIDTH);
    localparam int unsigned RowW = $clog2(HEIGHT);

    logic              start_in;
    logic              abort_in;
    logic              serpentine_in;
    logic              next_req_in;
    logic [ADDR_W-1:0] bram_addr_out;
    logic              bram_data_in;
    logic              pixel_out;
    logic              pixel_valid_out;
    logic              row_end_out;
    logic [ColW-1:0]   col_out;
    logic [RowW-1:0]   row_out;
    logic              freeze_out;
    logic              busy_out;
    logic              done_out;

    modport master (
        output start_in, abort_in, serpentine_in, next_req_in, bram_data_in,
        input  bram_addr_out, pixel_out, pixel_valid_out, row_end_out, col_out, row_out,
        input  freeze_out, busy_out, done_out
    );

    modport slave (
        input  start_in, abort_in, serpentine_in, next_req_in, bram_data_in,
        output bram_addr_out, pixel_out, pixel_valid_out, row_end_out, col_out, row_out,
        output freeze_out, busy_out, done_out
    );
endinterface

// File: rtl/plot_bitmap_scheduler.sv
// Streams the 1-bit bitmap to the plotter one pixel per request, in raster or serpentine order,
// waiting out the BRAM read latency after every address change.
module plot_bitmap_scheduler #(
    parameter int unsigned WIDTH        = 80,
    parameter int unsigned HEIGHT       = 106,
    parameter int unsigned ADDR_W       = 17,
    parameter int unsigned READ_LATENCY = 2
) (
    input logic                   clk_in,
    input logic                   rst_in,
    plot_bitmap_scheduler_if.slave bus
);
    localparam int unsigned ColW = $clog2(WIDTH);
    localparam int unsigned RowW = $clog2(HEIGHT);
    localparam int unsigned LatW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [ColW-1:0]   ColLast = ColW'(WIDTH - 1);
    localparam logic [RowW-1:0]   RowLast = RowW'(HEIGHT - 1);
    localparam logic [LatW-1:0]   LatLast = LatW'(READ_LATENCY - 1);
    localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(WIDTH);

    typedef enum logic [1:0] {StIdle, StSettle, StWaitReq, StDone} state_e;

    state_e            state_q, state_d;
    logic [LatW-1:0]   lat_q, lat_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [RowW-1:0]   row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              serp_q, serp_d;
    logic              pend_q, pend_d;
    logic              pix_q, pix_d;
    logic              valid_q, valid_d;
    logic              row_end_q, row_end_d;
    logic [ColW-1:0]   ocol_q, ocol_d;
    logic [RowW-1:0]   orow_q, orow_d;
    logic              done_q, done_d;

    logic descending;
    logic at_row_end;
    logic at_final;

    always_comb begin
        descending = serp_q & row_q[0];
        at_row_end = descending ? (col_q == '0) : (col_q == ColLast);
        at_final   = (row_q == RowLast) & at_row_end;
    end

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        col_d     = col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        serp_d    = serp_q;
        pend_d    = pend_q;
        pix_d     = pix_q;
        row_end_d = row_end_q;
        ocol_d    = ocol_q;
        orow_d    = orow_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;

        if (bus.abort_in) begin
            state_d = StIdle;
            pend_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start_in) begin
                        state_d = StSettle;
                        lat_d   = '0;
                        col_d   = '0;
                        row_d   = '0;
                        addr_d  = '0;
                        serp_d  = bus.serpentine_in;
                        pend_d  = 1'b0;
                    end
                end
                StSettle: begin
                    // One-deep: a second request while pending collapses into the first.
                    if (bus.next_req_in) pend_d = 1'b1;
                    if (lat_q == LatLast) state_d = StWaitReq;
                    else                  lat_d   = lat_q + LatW'(1);
                end
                StWaitReq: begin
                    if (bus.next_req_in || pend_q) begin
                        pix_d     = bus.bram_data_in;
                        ocol_d    = col_q;
                        orow_d    = row_q;
                        row_end_d = at_row_end;
                        valid_d   = 1'b1;
                        pend_d    = 1'b0;
                        if (at_final) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StSettle;
                            lat_d   = '0;
                            if (at_row_end) begin
                                // Serpentine turns around in place: same column, one row down.
                                row_d  = row_q + RowW'(1);
                                col_d  = serp_q ? col_q : '0;
                                addr_d = serp_q ? addr_q + RowStep : addr_q + ADDR_W'(1);
                            end else if (descending) begin
                                col_d  = col_q - ColW'(1);
                                addr_d = addr_q - ADDR_W'(1);
                            end else begin
                                col_d  = col_q + ColW'(1);
                                addr_d = addr_q + ADDR_W'(1);
                            end
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= StIdle;
            lat_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            serp_q    <= 1'b0;
            pend_q    <= 1'b0;
            pix_q     <= 1'b0;
            valid_q   <= 1'b0;
            row_end_q <= 1'b0;
            ocol_q    <= '0;
            orow_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            serp_q    <= serp_d;
            pend_q    <= pend_d;
            pix_q     <= pix_d;
            valid_q   <= valid_d;
            row_end_q <= row_end_d;
            ocol_q    <= ocol_d;
            orow_q    <= orow_d;
            done_q    <= done_d;
        end
    end

    assign bus.bram_addr_out   = addr_q;
    assign bus.pixel_out       = pix_q;
    assign bus.pixel_valid_out = valid_q;
    assign bus.row_end_out     = row_end_q;
    assign bus.col_out         = ocol_q;
    assign bus.row_out         = orow_q;
    assign bus.busy_out        = (state_q != StIdle);
    assign bus.freeze_out      = (state_q != StIdle);
    assign bus.done_out        = done_q;
endmodule

// File: tb/tb_plot_bitmap_scheduler.sv
// Directed bench for plot_bitmap_scheduler on a 4x3 bitmap with bitmap[a] = a[0] and a
// two-cycle BRAM model.
module tb_plot_bitmap_scheduler;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned AW = 17;
    localparam int unsigned L  = 2;

    typedef struct packed {
        logic [16:0] addr;
        logic [1:0]  col;
        logic [1:0]  row;
        logic        pix;
        logic        row_end;
        logic        done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    plot_bitmap_scheduler_if #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) bus ();

    plot_bitmap_scheduler #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .READ_LATENCY(L)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    logic p1, p2;
    always_ff @(posedge clk) begin
        p1 <= bus.bram_addr_out[0];
        p2 <= p1;
    end
    assign bus.bram_data_in = p2;

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[24];

    function automatic vec_t mk(int addr, int col, int row, int pix, int re, int done);
        vec_t v;
        v.addr    = 17'(addr);
        v.col     = 2'(col);
        v.row     = 2'(row);
        v.pix     = 1'(pix);
        v.row_end = 1'(re);
        v.done    = 1'(done);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Accepts a start and returns in the first WAIT_REQ cycle (T+L+1).
    task automatic do_start(input logic serp);
        bus.start_in      = 1'b1;
        bus.serpentine_in = serp;
        cyc();
        bus.start_in = 1'b0;
        check("start.busy", bus.busy_out, 1);
        check("start.freeze", bus.freeze_out, 1);
        cyc();
        cyc();
    endtask

    // Requests one pixel from WAIT_REQ and occupies the 6-cycle request slot.
    task automatic serve(input vec_t v, input string tag);
        int extra;
        check({tag, ".addr"}, bus.bram_addr_out, v.addr);
        bus.next_req_in = 1'b1;
        cyc();
        bus.next_req_in = 1'b0;
        check({tag, ".valid"}, bus.pixel_valid_out, 1);
        check({tag, ".pix"}, bus.pixel_out, v.pix);
        check({tag, ".col"}, bus.col_out, v.col);
        check({tag, ".row"}, bus.row_out, v.row);
        check({tag, ".row_end"}, bus.row_end_out, v.row_end);
        check({tag, ".done"}, bus.done_out, v.done);
        if (v.done) begin
            cyc();
            check({tag, ".busy_after"}, bus.busy_out, 0);
            check({tag, ".freeze_after"}, bus.freeze_out, 0);
            check({tag, ".done_after"}, bus.done_out, 0);
        end else begin
            extra = 0;
            for (int k = 0; k < 5; k++) begin
                cyc();
                if (bus.pixel_valid_out) extra++;
            end
            check({tag, ".extra_strobes"}, extra, 0);
        end
    endtask

    task automatic do_abort();
        bus.abort_in = 1'b1;
        cyc();
        bus.abort_in = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        bus.start_in      = 1'b0;
        bus.abort_in      = 1'b0;
        bus.serpentine_in = 1'b0;
        bus.next_req_in   = 1'b0;

        // Raster rows, then serpentine rows.
        vecs[0]  = mk(0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 1, 0, 0);
        vecs[2]  = mk(2, 2, 0, 0, 0, 0);
        vecs[3]  = mk(3, 3, 0, 1, 1, 0);
        vecs[4]  = mk(4, 0, 1, 0, 0, 0);
        vecs[5]  = mk(5, 1, 1, 1, 0, 0);
        vecs[6]  = mk(6, 2, 1, 0, 0, 0);
        vecs[7]  = mk(7, 3, 1, 1, 1, 0);
        vecs[8]  = mk(8, 0, 2, 0, 0, 0);
        vecs[9]  = mk(9, 1, 2, 1, 0, 0);
        vecs[10] = mk(10, 2, 2, 0, 0, 0);
        vecs[11] = mk(11, 3, 2, 1, 1, 1);
        vecs[12] = mk(0, 0, 0, 0, 0, 0);
        vecs[13] = mk(1, 1, 0, 1, 0, 0);
        vecs[14] = mk(2, 2, 0, 0, 0, 0);
        vecs[15] = mk(3, 3, 0, 1, 1, 0);
        vecs[16] = mk(7, 3, 1, 1, 0, 0);
        vecs[17] = mk(6, 2, 1, 0, 0, 0);
        vecs[18] = mk(5, 1, 1, 1, 0, 0);
        vecs[19] = mk(4, 0, 1, 0, 1, 0);
        vecs[20] = mk(8, 0, 2, 0, 0, 0);
        vecs[21] = mk(9, 1, 2, 1, 0, 0);
        vecs[22] = mk(10, 2, 2, 0, 0, 0);
        vecs[23] = mk(11, 3, 2, 1, 1, 1);

        repeat (3) cyc();
        check("rst.addr", bus.bram_addr_out, 0);
        check("rst.valid", bus.pixel_valid_out, 0);
        check("rst.busy", bus.busy_out, 0);
        check("rst.freeze", bus.freeze_out, 0);
        check("rst.done", bus.done_out, 0);
        check("rst.col", bus.col_out, 0);
        check("rst.row", bus.row_out, 0);
        rst = 1'b0;
        cyc();

        for (int s = 0; s < 2; s++) begin
            do_start(s[0]);
            for (int i = 0; i < 12; i++)
                serve(vecs[s * 12 + i], $sformatf("%s%0d", (s == 0) ? "raster" : "serp", i));
        end

        // Asynchronous reset mid-plot after three pixels.
        do_start(1'b0);
        for (int i = 0; i < 3; i++) serve(vecs[i], $sformatf("prerst%0d", i));
        #2;
        rst = 1'b1;
        #1;
        check("midrst.addr", bus.bram_addr_out, 0);
        check("midrst.busy", bus.busy_out, 0);
        check("midrst.freeze", bus.freeze_out, 0);
        check("midrst.col", bus.col_out, 0);
        check("midrst.valid", bus.pixel_valid_out, 0);
        cyc();
        rst = 1'b0;
        cyc();
        do_start(1'b0);
        serve(vecs[0], "postrst0");
        do_abort();

        // Request during SETTLE is pended; a second one there is dropped.
        do_start(1'b0);
        bus.next_req_in = 1'b1;
        cyc();
        check("pend.first_valid", bus.pixel_valid_out, 1);
        cyc();
        cyc();
        bus.next_req_in = 1'b0;
        check("pend.entry_valid", bus.pixel_valid_out, 0);
        cyc();
        check("pend.valid", bus.pixel_valid_out, 1);
        check("pend.col", bus.col_out, 1);
        check("pend.pix", bus.pixel_out, 1);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (bus.pixel_valid_out) cnt++;
        end
        check("pend.dropped", cnt, 0);
        check("pend.addr", bus.bram_addr_out, 2);
        do_abort();

        // Abort coincident with a request after the fifth strobe.
        do_start(1'b0);
        for (int i = 0; i < 5; i++) serve(vecs[i], $sformatf("preabort%0d", i));
        bus.abort_in    = 1'b1;
        bus.next_req_in = 1'b1;
        cyc();
        bus.abort_in    = 1'b0;
        bus.next_req_in = 1'b0;
        check("abort.valid", bus.pixel_valid_out, 0);
        check("abort.done", bus.done_out, 0);
        check("abort.busy", bus.busy_out, 0);
        check("abort.freeze", bus.freeze_out, 0);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (bus.pixel_valid_out || bus.done_out || bus.busy_out) cnt++;
        end
        check("abort.quiet", cnt, 0);
        do_start(1'b0);
        serve(vecs[0], "restart0");
        do_abort();

        // Start while busy (with serpentine requested) must not restart or reorder.
        bus.start_in = 1'b1;
        cyc();
        bus.start_in      = 1'b1;
        bus.serpentine_in = 1'b1;
        cyc();
        bus.start_in      = 1'b0;
        bus.serpentine_in = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) serve(vecs[i], $sformatf("busystart%0d", i));
        do_abort();

        // Request in IDLE, then start+abort together in IDLE.
        bus.next_req_in = 1'b1;
        cyc();
        bus.next_req_in = 1'b0;
        check("idlereq.valid", bus.pixel_valid_out, 0);
        check("idlereq.busy", bus.busy_out, 0);
        cyc();
        check("idlereq.valid2", bus.pixel_valid_out, 0);
        bus.start_in = 1'b1;
        bus.abort_in = 1'b1;
        cyc();
        bus.start_in = 1'b0;
        bus.abort_in = 1'b0;
        check("startabort.busy", bus.busy_out, 0);
        cyc();
        check("startabort.busy2", bus.busy_out, 0);
        check("startabort.freeze", bus.freeze_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
